sumcheck_round_verifier: RTL and testbench
==========================================

// Module: sumcheck_round_verifier
// PURPOSE
//   Parametrised sum-check verifier for one GKR layer over GF(PRIME). Runs NUM_VARS rounds against a prover
//   sending degree-2 round polynomials as evaluations g(0),g(1),g(2) and checks g(0)+g(1)==claim.
//   Folds each round with a random challenge and hands the final point r_vec to an external oracle for the last check.
//   Sits between the layer-sequencing verifier FSM and the prover/wiring-predicate datapath.
// PARAMETERS
//   NUM_VARS  6           rounds = variables summed over (>=1)
//   FIELD_W   32          field element width (bits)
//   PRIME     2147483647  field modulus, odd, < 2**FIELD_W
//   RND_W     $clog2(NUM_VARS+1)  round counter width
// PORTS
//   clk          in   1                 clock
//   rst          in   1                 asynchronous reset, active-high
//   start        in   1                 1-cycle pulse: latch claim, begin round 0
//   claim        in   FIELD_W           initial claimed sum
//   poly_valid   in   1                 prover round polynomial valid
//   poly_ready   out  1                 verifier can accept polynomial
//   poly_eval    in   3 x FIELD_W       g(0), g(1), g(2)
//   chal         in   FIELD_W           random challenge, sampled on poly handshake
//   r_vec        out  NUM_VARS*FIELD_W  challenges; round i at [i*FIELD_W +: FIELD_W]
//   oracle_req   out  1                 r_vec complete, request f(r_vec)
//   oracle_valid in   1                 oracle_val valid
//   oracle_val   in   FIELD_W           f(r_vec) from oracle
//   final_claim  out  FIELD_W           running claim (g_last(r_last) after last round)
//   round        out  RND_W             current round index
//   done         out  1                 verdict valid; held until next start
//   accept       out  1                 verdict; meaningful only while done=1
// BEHAVIOUR
//   Reset: state IDLE; poly_ready,oracle_req,done,accept=0; round,final_claim,r_vec=0.
//   FSM: IDLE -start-> WAIT_POLY -hs-> CHECK -ok-> INTERP(7 cyc) -> WAIT_POLY (round+1) | ORACLE (last round);
//        CHECK -fail-> DONE(accept=0); ORACLE -oracle_valid-> DONE; DONE -start-> WAIT_POLY.
//   start in IDLE/DONE: latch claim into final_claim, round=0, clear done/accept. start elsewhere ignored.
//   Handshake: transfer when poly_valid&&poly_ready (cycle 0); poly_eval and chal latched at cycle 0.
//     poly_ready high only in WAIT_POLY; low from cycle 1. CHECK at cycle 1; INTERP cycles 2..8;
//     poly_ready re-high at cycle 9 for next round. chal written to r_vec slot `round` at cycle 0.
//   CHECK fails if any of g0,g1,g2,chal >= PRIME, or (g0+g1) mod PRIME != final_claim; DONE entered cycle 2.
//   INTERP (Lagrange on 0,1,2, INV2=(PRIME+1)/2, one shared mod_mul, 1 product/cycle):
//     a=r(r-1), b=r(r-2), c=(r-1)(r-2), g0*c, g1*b, g2*a, (g0c+g2a)*INV2; final_claim = that - g1b.
//   Arithmetic: all values canonical [0,PRIME); add/sub use FIELD_W+1 bits, single conditional correction;
//     mul forms 2*FIELD_W product then reduces mod PRIME.
//   ORACLE: oracle_req=1, r_vec stable; on oracle_valid accept=(oracle_val==final_claim), done=1 next cycle.
//   claim >= PRIME at start: straight to DONE, accept=0. oracle_valid outside ORACLE ignored.
//   rst mid-operation: immediate return to reset state; partial r_vec discarded.
// CONFIGURATION
//   SUMCHECK_FAIL_INFO_EN defined: extra outputs fail_round[RND_W] (round of rejection, NUM_VARS if
//     oracle mismatch) and fail_code[2] (0 none,1 non-canonical,2 sum mismatch,3 oracle mismatch),
//     valid with done, reset 0. Undefined: ports absent, verdict logic identical.
// STRUCTURE
//   sumcheck_pkg: NUM_EVALS=3, INTERP_CYCLES=7, state enum (IDLE,WAIT_POLY,CHECK,INTERP,ORACLE,DONE),
//     fail_code enum, mod_add/mod_sub functions parametrised on PRIME.
//   Sub-module mod_mul: registered modular multiplier, 1-cycle latency, params FIELD_W/PRIME.
// TESTING (NUM_VARS=2 unless stated, default PRIME)
//   Honest f=x1+2*x2: claim 6; R0 evals 2,4,6 chal 5 -> claim 12; R1 evals 5,7,9 chal 3 -> final_claim 11,
//     oracle_req; oracle_val 11 -> done=1, accept=1, r_vec={3,5}.
//   Same, R0 evals 3,4,6 -> done at cycle 2, accept=0, round=0, poly_ready stays 0 (fail_code 2).
//   Honest rounds, oracle_val 10 -> accept=0 (fail_round 2, fail_code 3).
//   Wrap: NUM_VARS=1, claim 1, evals 0,1,2, chal PRIME-1 -> final_claim PRIME-1; oracle PRIME-1 -> accept=1.
//   Non-canonical: claim=PRIME or g2=PRIME -> accept=0; start pulsed in INTERP ignored.
//   rst asserted at INTERP cycle 4 -> all outputs at reset values; new start completes honest run normally.

Source files
------------

// File: rtl/sumcheck_pkg.sv
// Shared types and field helpers for the sum-check round verifier.
// Optional SUMCHECK_FAIL_INFO_EN adds rejection diagnostics to the verifier.
package sumcheck_pkg;

    localparam int NUM_EVALS     = 3;
    localparam int INTERP_CYCLES = 7;
    localparam int MAX_W         = 64;

    typedef logic [MAX_W-1:0] felem_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_POLY,
        CHECK,
        INTERP,
        ORACLE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_NONCANON,
        FC_SUM,
        FC_ORACLE
    } fail_code_t;

    // Inputs are canonical, so one conditional correction suffices.
    function automatic felem_t mod_add(input felem_t a, input felem_t b,
                                       input felem_t p);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[MAX_W-1:0];
    endfunction

    function automatic felem_t mod_sub(input felem_t a, input felem_t b,
                                       input felem_t p);
        return (a >= b) ? (a - b) : (a - b + p);
    endfunction

endpackage

// File: rtl/sumcheck_round_verifier_if.sv
// Handshake bundle between layer FSM, prover, oracle and the round verifier.
// Fail-info signals exist only when SUMCHECK_FAIL_INFO_EN is defined.
interface sumcheck_round_verifier_if #(
    parameter int NUM_VARS = 6,
    parameter int FIELD_W  = 32,
    parameter int RND_W    = $clog2(NUM_VARS + 1)
);
    import sumcheck_pkg::*;

    logic                                start;
    logic [FIELD_W-1:0]                  claim;
    logic                                poly_valid;
    logic                                poly_ready;
    logic [NUM_EVALS-1:0][FIELD_W-1:0]   poly_eval;
    logic [FIELD_W-1:0]                  chal;
    logic [NUM_VARS*FIELD_W-1:0]         r_vec;
    logic                                oracle_req;
    logic                                oracle_valid;
    logic [FIELD_W-1:0]                  oracle_val;
    logic [FIELD_W-1:0]                  final_claim;
    logic [RND_W-1:0]                    round;
    logic                                done;
    logic                                accept;
`ifdef SUMCHECK_FAIL_INFO_EN
    logic [RND_W-1:0]                    fail_round;
    logic [1:0]                          fail_code;

    modport master (
        output start, claim, poly_valid, poly_eval, chal,
        output oracle_valid, oracle_val,
        input  poly_ready, r_vec, oracle_req, final_claim,
        input  round, done, accept, fail_round, fail_code
    );
    modport slave (
        input  start, claim, poly_valid, poly_eval, chal,
        input  oracle_valid, oracle_val,
        output poly_ready, r_vec, oracle_req, final_claim,
        output round, done, accept, fail_round, fail_code
    );
`else
    modport master (
        output start, claim, poly_valid, poly_eval, chal,
        output oracle_valid, oracle_val,
        input  poly_ready, r_vec, oracle_req, final_claim,
        input  round, done, accept
    );
    modport slave (
        input  start, claim, poly_valid, poly_eval, chal,
        input  oracle_valid, oracle_val,
        output poly_ready, r_vec, oracle_req, final_claim,
        output round, done, accept
    );
`endif

endinterface

// File: rtl/mod_mul.sv
// Registered modular multiplier: p = a*b mod PRIME, one cycle of latency.
module mod_mul #(
    parameter int                 FIELD_W = 32,
    parameter logic [FIELD_W-1:0] PRIME   = FIELD_W'(2147483647)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FIELD_W-1:0] a,
    input  logic [FIELD_W-1:0] b,
    output logic [FIELD_W-1:0] p
);
    logic [2*FIELD_W-1:0] prod;

    assign prod = {{FIELD_W{1'b0}}, a} * {{FIELD_W{1'b0}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p <= '0;
        else     p <= FIELD_W'(prod % {{FIELD_W{1'b0}}, PRIME});
    end

endmodule

// File: rtl/sumcheck_round_verifier.sv
// Sum-check verifier for one GKR layer with degree-2 rounds over GF(PRIME).
// Define SUMCHECK_FAIL_INFO_EN to expose fail_round/fail_code diagnostics.
module sumcheck_round_verifier
    import sumcheck_pkg::*;
#(
    parameter int                 NUM_VARS = 6,
    parameter int                 FIELD_W  = 32,
    parameter logic [FIELD_W-1:0] PRIME    = FIELD_W'(2147483647),
    parameter int                 RND_W    = $clog2(NUM_VARS + 1)
) (
    input logic                     clk,
    input logic                     rst,
    sumcheck_round_verifier_if.slave bus
);
    typedef logic [FIELD_W-1:0] fe_t;

    localparam logic [FIELD_W:0] P_PLUS1 = {1'b0, PRIME} + 1'b1;
    localparam fe_t INV2 = P_PLUS1[FIELD_W:1];
    localparam fe_t ONE  = fe_t'(1);
    localparam fe_t TWO  = fe_t'(2);

    function automatic fe_t fadd(input fe_t x, input fe_t y);
        return fe_t'(mod_add(felem_t'(x), felem_t'(y), felem_t'(PRIME)));
    endfunction

    function automatic fe_t fsub(input fe_t x, input fe_t y);
        return fe_t'(mod_sub(felem_t'(x), felem_t'(y), felem_t'(PRIME)));
    endfunction

    state_t                            state;
    logic [NUM_EVALS-1:0][FIELD_W-1:0] g;
    fe_t                               r, a_q, b_q, t0, g1b;
    fe_t                               mul_a, mul_b, mul_q, rm1, rm2;
    fe_t                               final_claim;
    logic [2:0]                        icnt;
    logic [RND_W-1:0]                  round;
    logic [NUM_VARS-1:0][FIELD_W-1:0]  r_vec;
    logic                              poly_ready, oracle_req;
    logic                              done, accept;
    logic                              noncanon, sum_bad;
`ifdef SUMCHECK_FAIL_INFO_EN
    logic [RND_W-1:0]                  fail_round;
    fail_code_t                        fail_code;

    assign bus.fail_round = fail_round;
    assign bus.fail_code  = fail_code;
`endif

    assign bus.poly_ready  = poly_ready;
    assign bus.oracle_req  = oracle_req;
    assign bus.done        = done;
    assign bus.accept      = accept;
    assign bus.round       = round;
    assign bus.final_claim = final_claim;
    assign bus.r_vec       = r_vec;

    assign rm1      = fsub(r, ONE);
    assign rm2      = fsub(r, TWO);
    assign noncanon = (g[0] >= PRIME) || (g[1] >= PRIME) ||
                      (g[2] >= PRIME) || (r >= PRIME);
    assign sum_bad  = fadd(g[0], g[1]) != final_claim;

    mod_mul #(
        .FIELD_W(FIELD_W),
        .PRIME  (PRIME)
    ) u_mul (
        .clk(clk),
        .rst(rst),
        .a  (mul_a),
        .b  (mul_b),
        .p  (mul_q)
    );

    // r(r-1) is issued during CHECK so all seven products fit in INTERP.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == CHECK) begin
            mul_a = r;
            mul_b = rm1;
        end else if (state == INTERP) begin
            case (icnt)
                3'd0: begin mul_a = r;                mul_b = rm2;   end
                3'd1: begin mul_a = rm1;              mul_b = rm2;   end
                3'd2: begin mul_a = g[0];             mul_b = mul_q; end
                3'd3: begin mul_a = g[1];             mul_b = b_q;   end
                3'd4: begin mul_a = g[2];             mul_b = a_q;   end
                3'd5: begin mul_a = fadd(t0, mul_q);  mul_b = INV2;  end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            poly_ready  <= 1'b0;
            oracle_req  <= 1'b0;
            done        <= 1'b0;
            accept      <= 1'b0;
            g           <= '0;
            r           <= '0;
            a_q         <= '0;
            b_q         <= '0;
            t0          <= '0;
            g1b         <= '0;
            icnt        <= '0;
            round       <= '0;
            r_vec       <= '0;
            final_claim <= '0;
`ifdef SUMCHECK_FAIL_INFO_EN
            fail_round  <= '0;
            fail_code   <= FC_NONE;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        final_claim <= bus.claim;
                        round       <= '0;
                        done        <= 1'b0;
                        accept      <= 1'b0;
`ifdef SUMCHECK_FAIL_INFO_EN
                        fail_round  <= '0;
                        fail_code   <= FC_NONE;
`endif
                        if (bus.claim >= PRIME) begin
                            state <= DONE;
                            done  <= 1'b1;
`ifdef SUMCHECK_FAIL_INFO_EN
                            fail_code <= FC_NONCANON;
`endif
                        end else begin
                            state      <= WAIT_POLY;
                            poly_ready <= 1'b1;
                        end
                    end
                end
                WAIT_POLY: begin
                    if (bus.poly_valid && poly_ready) begin
                        g          <= bus.poly_eval;
                        r          <= bus.chal;
                        poly_ready <= 1'b0;
                        state      <= CHECK;
                        for (int i = 0; i < NUM_VARS; i++) begin
                            if (round == RND_W'(i)) r_vec[i] <= bus.chal;
                        end
                    end
                end
                CHECK: begin
                    if (noncanon || sum_bad) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        accept <= 1'b0;
`ifdef SUMCHECK_FAIL_INFO_EN
                        fail_round <= round;
                        fail_code  <= noncanon ? FC_NONCANON : FC_SUM;
`endif
                    end else begin
                        state <= INTERP;
                        icnt  <= '0;
                    end
                end
                INTERP: begin
                    icnt <= icnt + 1'b1;
                    case (icnt)
                        3'd0: a_q <= mul_q;
                        3'd1: b_q <= mul_q;
                        3'd3: t0  <= mul_q;
                        3'd4: g1b <= mul_q;
                        default: ;
                    endcase
                    if (icnt == 3'(INTERP_CYCLES - 1)) begin
                        final_claim <= fsub(mul_q, g1b);
                        round       <= round + 1'b1;
                        if (round == RND_W'(NUM_VARS - 1)) begin
                            state      <= ORACLE;
                            oracle_req <= 1'b1;
                        end else begin
                            state      <= WAIT_POLY;
                            poly_ready <= 1'b1;
                        end
                    end
                end
                ORACLE: begin
                    if (bus.oracle_valid) begin
                        state      <= DONE;
                        oracle_req <= 1'b0;
                        done       <= 1'b1;
                        accept     <= (bus.oracle_val == final_claim);
`ifdef SUMCHECK_FAIL_INFO_EN
                        if (bus.oracle_val != final_claim) begin
                            fail_round <= RND_W'(NUM_VARS);
                            fail_code  <= FC_ORACLE;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumcheck_round_verifier.sv
// Scoreboard bench for sumcheck_round_verifier, NUM_VARS=2, default PRIME.
// Expected verdicts come from an independent Newton-form round model.
module tb_sumcheck_round_verifier;
    import sumcheck_pkg::*;

    localparam int              NV = 2;
    localparam int              W  = 32;
    localparam int              RW = $clog2(NV + 1);
    localparam longint unsigned P  = 64'd2147483647;
    localparam logic [W-1:0]    PW = 32'd2147483647;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sumcheck_round_verifier_if #(.NUM_VARS(NV), .FIELD_W(W)) bus ();

    sumcheck_round_verifier #(
        .NUM_VARS(NV),
        .FIELD_W (W),
        .PRIME   (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          acc;
        logic [W-1:0]  fc;
        logic [1:0]    code;
        logic [RW-1:0] frnd;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] cur_claim;
    logic [W-1:0] cur_orc;
    logic [W-1:0] cur_ev[NV][3];
    logic [W-1:0] cur_ch[NV];
    bit           poke_start = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned madd(input longint unsigned a,
                                             input longint unsigned b);
        return (a + b) % P;
    endfunction

    function automatic longint unsigned msub(input longint unsigned a,
                                             input longint unsigned b);
        return (a + P - b) % P;
    endfunction

    function automatic longint unsigned mmul(input longint unsigned a,
                                             input longint unsigned b);
        return (a * b) % P;
    endfunction

    // Newton form: g(x) = g0 + d1*x + d2*x(x-1)/2
    function automatic longint unsigned geval(input longint unsigned g0,
                                              input longint unsigned g1,
                                              input longint unsigned g2,
                                              input longint unsigned r);
        longint unsigned d1, d2, hx;
        d1 = msub(g1, g0);
        d2 = msub(madd(g2, g0), madd(g1, g1));
        hx = mmul(mmul(r, msub(r, 1)), (P + 1) / 2);
        return madd(madd(g0, mmul(d1, r)), mmul(d2, hx));
    endfunction

    task automatic set_case(input logic [W-1:0] cl,
                            input logic [W-1:0] e00, input logic [W-1:0] e01,
                            input logic [W-1:0] e02, input logic [W-1:0] e10,
                            input logic [W-1:0] e11, input logic [W-1:0] e12,
                            input logic [W-1:0] c0, input logic [W-1:0] c1,
                            input logic [W-1:0] orc);
        cur_claim    = cl;
        cur_ev[0][0] = e00; cur_ev[0][1] = e01; cur_ev[0][2] = e02;
        cur_ev[1][0] = e10; cur_ev[1][1] = e11; cur_ev[1][2] = e12;
        cur_ch[0]    = c0;
        cur_ch[1]    = c1;
        cur_orc      = orc;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rdy"}, 64'(bus.poly_ready), 64'(0));
        chk({tag, "_oreq"}, 64'(bus.oracle_req), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_acc"}, 64'(bus.accept), 64'(0));
        chk({tag, "_round"}, 64'(bus.round), 64'(0));
        chk({tag, "_fc"}, 64'(bus.final_claim), 64'(0));
        chk({tag, "_rvec"}, 64'(bus.r_vec), 64'(0));
    endtask

    task automatic run_case(input string tag);
        exp_t            e, got;
        bit              okr[NV];
        longint unsigned cr[NV];
        longint unsigned c;
        bit              fail, go;
        int              n;
        c      = cur_claim;
        fail   = (cur_claim >= PW);
        e.code = fail ? 2'd1 : 2'd0;
        e.frnd = '0;
        for (int rr = 0; rr < NV; rr++) begin
            okr[rr] = 0;
            cr[rr]  = 0;
            if (!fail) begin
                if (cur_ev[rr][0] >= PW || cur_ev[rr][1] >= PW ||
                    cur_ev[rr][2] >= PW || cur_ch[rr] >= PW) begin
                    fail = 1; e.code = 2'd1; e.frnd = RW'(rr);
                end else if (madd(cur_ev[rr][0], cur_ev[rr][1]) != c) begin
                    fail = 1; e.code = 2'd2; e.frnd = RW'(rr);
                end else begin
                    okr[rr] = 1;
                    c = geval(cur_ev[rr][0], cur_ev[rr][1],
                              cur_ev[rr][2], cur_ch[rr]);
                    cr[rr] = c;
                end
            end
        end
        e.acc = !fail && (64'(cur_orc) == c);
        if (!fail && !e.acc) begin
            e.code = 2'd3;
            e.frnd = RW'(NV);
        end
        e.fc = W'(c);
        sbq.push_back(e);

        @(negedge clk);
        bus.start = 1'b1;
        bus.claim = cur_claim;
        @(negedge clk);
        bus.start = 1'b0;
        go = (cur_claim < PW);
        for (int rr = 0; rr < NV; rr++) begin
            if (go) begin
                n = 0;
                while (!bus.poly_ready && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk({tag, "_ready"}, 64'(bus.poly_ready), 64'(1));
                bus.poly_valid = 1'b1;
                bus.poly_eval  = {cur_ev[rr][2], cur_ev[rr][1], cur_ev[rr][0]};
                bus.chal       = cur_ch[rr];
                @(negedge clk);
                bus.poly_valid = 1'b0;
                chk({tag, "_rdy_low"}, 64'(bus.poly_ready), 64'(0));
                n = 0;
                while (!(bus.poly_ready || bus.done || bus.oracle_req) &&
                       n < 40) begin
                    if (poke_start && rr == 0 && n == 2) begin
                        bus.start = 1'b1;
                        bus.claim = 32'd99;
                    end else begin
                        bus.start = 1'b0;
                    end
                    @(negedge clk);
                    n++;
                end
                bus.start = 1'b0;
                chk({tag, "_lat"}, 64'(n), okr[rr] ? 64'(8) : 64'(1));
                if (okr[rr])
                    chk({tag, "_rclaim"}, 64'(bus.final_claim), cr[rr]);
                else
                    go = 0;
            end
        end
        if (go) begin
            n = 0;
            while (!bus.oracle_req && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_oreq"}, 64'(bus.oracle_req), 64'(1));
            bus.oracle_valid = 1'b1;
            bus.oracle_val   = cur_orc;
            @(negedge clk);
            bus.oracle_valid = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
        got = sbq.pop_front();
        chk({tag, "_accept"}, 64'(bus.accept), 64'(got.acc));
        chk({tag, "_final"}, 64'(bus.final_claim), 64'(got.fc));
`ifdef SUMCHECK_FAIL_INFO_EN
        chk({tag, "_fcode"}, 64'(bus.fail_code), 64'(got.code));
        chk({tag, "_fround"}, 64'(bus.fail_round), 64'(got.frnd));
`endif
    endtask

    initial begin
        int n;
        bus.start        = 1'b0;
        bus.claim        = '0;
        bus.poly_valid   = 1'b0;
        bus.poly_eval    = '0;
        bus.chal         = '0;
        bus.oracle_valid = 1'b0;
        bus.oracle_val   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        set_case(6, 2, 4, 6, 5, 7, 9, 5, 3, 11);
        run_case("honest");
        chk("honest_rvec", 64'(bus.r_vec), {32'd3, 32'd5});

        set_case(6, 3, 4, 6, 5, 7, 9, 5, 3, 11);
        run_case("badsum");
        chk("badsum_round", 64'(bus.round), 64'(0));
        repeat (3) @(negedge clk);
        chk("badsum_rdy_held", 64'(bus.poly_ready), 64'(0));
        chk("badsum_done_held", 64'(bus.done), 64'(1));

        set_case(6, 2, 4, 6, 5, 7, 9, 5, 3, 10);
        run_case("badorc");

        set_case(1, 0, 1, 2, 0, PW - 1, PW - 2, PW - 1, PW - 1, 1);
        run_case("wrap");

        set_case(PW, 2, 4, 6, 5, 7, 9, 5, 3, 11);
        run_case("claimP");

        set_case(6, 2, 4, 6, 5, 7, PW, 5, 3, 11);
        run_case("g2P");

        poke_start = 1;
        set_case(6, 2, 4, 6, 5, 7, 9, 5, 3, 11);
        run_case("poke");
        poke_start = 0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.claim = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.poly_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_ready", 64'(bus.poly_ready), 64'(1));
        bus.poly_valid = 1'b1;
        bus.poly_eval  = {32'd6, 32'd4, 32'd2};
        bus.chal       = 32'd5;
        @(negedge clk);
        bus.poly_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;

        set_case(6, 2, 4, 6, 5, 7, 9, 5, 3, 11);
        run_case("after_rst");
        chk("after_rst_rvec", 64'(bus.r_vec), {32'd3, 32'd5});

        chk("sb_drained", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
